// File: rtl/cl_pkg.sv
// Shared constants, types and FSM state encoding for the cache-line/word buffer.
package cl_pkg;

  localparam int unsigned LINE_WIDTH     = 512;
  localparam int unsigned WORD_WIDTH     = 32;
  localparam int unsigned WORDS_PER_LINE = LINE_WIDTH / WORD_WIDTH;
  localparam int unsigned IDX_WIDTH      = $clog2(WORDS_PER_LINE);

  typedef logic [LINE_WIDTH-1:0] line_t;
  typedef logic [WORD_WIDTH-1:0] word_t;
  typedef logic [IDX_WIDTH-1:0]  word_idx_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_WAIT,
    S_RD_STREAM,
    S_WR_FILL,
    S_WR_PUSH,
    S_DONE
  } buf_state_t;

endpackage

// File: rtl/cl_line_reg.sv
// Cache-line register: whole-line load, word-indexed write and word-indexed read mux.
module cl_line_reg
  import cl_pkg::*;
#(
  parameter int unsigned LINE_WIDTH = cl_pkg::LINE_WIDTH,
  parameter int unsigned WORD_WIDTH = cl_pkg::WORD_WIDTH,
  parameter int unsigned IDX_WIDTH  = cl_pkg::IDX_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_en,
  input  logic [LINE_WIDTH-1:0] load_line,
  input  logic                  wr_en,
  input  logic [IDX_WIDTH-1:0]  wr_idx,
  input  logic [WORD_WIDTH-1:0] wr_word,
  input  logic [IDX_WIDTH-1:0]  rd_idx,
  output logic [LINE_WIDTH-1:0] line,
  output logic [WORD_WIDTH-1:0] rd_word
);

  // Line storage: a full-line load takes priority over a single-word write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line <= '0;
    end else if (load_en) begin
      line <= load_line;
    end else if (wr_en) begin
      line[wr_idx*WORD_WIDTH +: WORD_WIDTH] <= wr_word;
    end
  end

  // Word select for the read side; word 0 sits in the LSBs.
  always_comb begin
    rd_word = line[rd_idx*WORD_WIDTH +: WORD_WIDTH];
  end

endmodule

// File: rtl/cl_word_buffer.sv
// Line/word width converter between the 512-bit DMA FIFOs and the 32-bit CPU bus.
module cl_word_buffer
  import cl_pkg::*;
#(
  parameter int unsigned LINE_WIDTH = cl_pkg::LINE_WIDTH,
  parameter int unsigned WORD_WIDTH = cl_pkg::WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_req,
  input  logic                  wr_req,
  input  logic                  abort,
  input  logic [WORD_WIDTH-1:0] word_in,
  input  logic                  word_in_valid,
  output logic                  word_in_ready,
  output logic [WORD_WIDTH-1:0] word_out,
  output logic                  word_out_valid,
  input  logic                  word_out_ready,
  input  logic [LINE_WIDTH-1:0] host_rd_data,
  input  logic                  host_rd_ready,
  output logic                  host_re,
  output logic [LINE_WIDTH-1:0] host_wr_data,
  input  logic                  host_wr_ready,
  output logic                  host_we,
  output logic                  ready,
  output logic                  tx_done
);

  localparam int unsigned WPL   = LINE_WIDTH / WORD_WIDTH;
  localparam int unsigned IDX_W = $clog2(WPL);

  typedef logic [IDX_W-1:0] idx_t;
  localparam idx_t LAST_IDX = idx_t'(WPL - 1);

  buf_state_t            state;
  idx_t                  idx;
  logic                  out_fire;
  logic                  in_fire;
  logic [LINE_WIDTH-1:0] line;
  logic [WORD_WIDTH-1:0] rd_word;

  // Handshake decode; abort masks every strobe and handshake in its cycle so
  // nothing is popped, pushed or consumed while the operation is being dropped.
  always_comb begin
    ready          = (state == S_IDLE);
    tx_done        = (state == S_DONE);
    host_re        = (state == S_RD_WAIT) && host_rd_ready && !abort;
    host_we        = (state == S_WR_PUSH) && host_wr_ready && !abort;
    word_out_valid = (state == S_RD_STREAM) && !abort;
    word_in_ready  = (state == S_WR_FILL) && !abort;
    out_fire       = word_out_valid && word_out_ready;
    in_fire        = word_in_ready && word_in_valid;
    word_out       = word_out_valid ? rd_word : '0;
    host_wr_data   = line;
  end

  // Control FSM and word index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      idx   <= '0;
    end else if (abort && state != S_IDLE) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rd_req) state <= S_RD_WAIT;
          else if (wr_req) begin
            state <= S_WR_FILL;
            idx   <= '0;
          end
        end
        S_RD_WAIT: begin
          if (host_re) begin
            state <= S_RD_STREAM;
            idx   <= '0;
          end
        end
        S_RD_STREAM: begin
          if (out_fire) begin
            idx <= idx + 1'b1;
            if (idx == LAST_IDX) state <= S_DONE;
          end
        end
        S_WR_FILL: begin
          if (in_fire) begin
            idx <= idx + 1'b1;
            if (idx == LAST_IDX) state <= S_WR_PUSH;
          end
        end
        S_WR_PUSH: begin
          if (host_we) state <= S_DONE;
        end
        S_DONE: state <= S_IDLE;
        default: begin
          state <= S_IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

  cl_line_reg #(
    .LINE_WIDTH (LINE_WIDTH),
    .WORD_WIDTH (WORD_WIDTH),
    .IDX_WIDTH  (IDX_W)
  ) u_line_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_en   (host_re),
    .load_line (host_rd_data),
    .wr_en     (in_fire),
    .wr_idx    (idx),
    .wr_word   (word_in),
    .rd_idx    (idx),
    .line      (line),
    .rd_word   (rd_word)
  );

endmodule

// File: doc/cl_word_buffer.md
Name: cl_word_buffer

Overview:
- Converts between the 512-bit cache-line DMA data path and the 32-bit CPU common data bus.
- Read: fetches one line from the DMA read FIFO and streams it to the CPU as 16 words.
- Write: collects 16 CPU words, packs them into one line, and pushes it into the DMA write FIFO.
- Sits between the memory controller's CPU-facing side and the dma_if rd_data/wr_data channels. It owns all line/word width conversion.

Parameters:
- LINE_WIDTH, 512, cache-line width in bits.
- WORD_WIDTH, 32, CPU bus word width in bits.
- WORDS_PER_LINE, LINE_WIDTH/WORD_WIDTH (16), derived constant; not overridable.

Ports:
- clk  in  1  single system clock.
- rst_n  in  1  asynchronous, active-low reset.
- rd_req  in  1  one-cycle pulse: fetch one line and stream it out.
- wr_req  in  1  one-cycle pulse: collect one line of words and write it.
- abort  in  1  synchronous: drop the current operation and return to IDLE.
- word_in  in  WORD_WIDTH  CPU write word.
- word_in_valid  in  1  word_in is valid this cycle.
- word_in_ready  out  1  block accepts word_in this cycle.
- word_out  out  WORD_WIDTH  CPU read word.
- word_out_valid  out  1  word_out is valid.
- word_out_ready  in  1  CPU consumes word_out this cycle.
- host_rd_data  in  LINE_WIDTH  DMA read FIFO head (first-word-fall-through).
- host_rd_ready  in  1  DMA read FIFO not empty.
- host_re  out  1  DMA read enable (pop).
- host_wr_data  out  LINE_WIDTH  packed line to the DMA write FIFO.
- host_wr_ready  in  1  DMA write FIFO not full.
- host_we  out  1  DMA write enable (push).
- ready  out  1  high only in IDLE.
- tx_done  out  1  one-cycle pulse when an operation completes.

Behaviour:
- Reset: state IDLE, word index 0, line register 0. All outputs 0 except ready=1. Reset asserted mid-operation discards the partial line and issues no host strobe.
- States: IDLE, RD_WAIT, RD_STREAM, WR_FILL, WR_PUSH, DONE.
- IDLE:
  - rd_req -> RD_WAIT; wr_req -> WR_FILL.
  - If both are asserted in the same cycle, rd_req wins and wr_req is dropped.
  - Requests are ignored in every state other than IDLE.
- RD_WAIT:
  - host_re = host_rd_ready (combinational, asserted only in this state).
  - On the host_re cycle, capture host_rd_data into the line register, clear the index, and go to RD_STREAM.
  - Waits indefinitely while the FIFO is empty.
- RD_STREAM:
  - word_out = line[index*32 +: 32]; word_out_valid=1.
  - On word_out_valid & word_out_ready, increment index.
  - When word 15 is consumed -> DONE.
  - Word 0 is LSBs. First word is visible 1 cycle after host_re.
- WR_FILL:
  - word_in_ready=1. On word_in_valid, write line[index*32 +: 32] and increment index.
  - When word 15 is accepted -> WR_PUSH.
- WR_PUSH:
  - host_wr_data = line register, held stable.
  - host_we = host_wr_ready (combinational). On the host_we cycle -> DONE.
  - Waits indefinitely while the FIFO is full.
- DONE: tx_done=1 for exactly one cycle, then -> IDLE.
- Index is 4 bits and wraps 15->0 only on the final transfer; it is never observed past 15.
- abort in any non-IDLE state:
  - next cycle the state is IDLE, index is 0, no tx_done.
  - host_re/host_we are suppressed in the abort cycle.
- host_re and host_we are never asserted together and never more than one cycle per operation.
- Best-case latency:
  - read: rd_req -> tx_done = 18 cycles with ready FIFO and CPU.
  - write: wr_req -> tx_done = 18 cycles.

Decomposition:
- Shared package cl_pkg:
  - LINE_WIDTH, WORD_WIDTH, WORDS_PER_LINE.
  - typedefs line_t, word_t, word_idx_t.
  - enum buf_state_t.
- Sub-module cl_line_reg: 512-bit line register with a word-indexed write port and a word-indexed read mux. The FSM lives in cl_word_buffer.

Test Plan:
- Read: host_rd_data = {16 words 0x0F..0x00}, host_rd_ready=1, word_out_ready=1, pulse rd_req -> host_re single pulse; word_out 0x00..0x0F on consecutive cycles; tx_done once.
- Write: pulse wr_req, drive words 0xA0..0xAF, host_wr_ready=1 -> one host_we; host_wr_data[31:0]=0xA0, [511:480]=0xAF; tx_done once.
- Backpressure:
  - read with host_rd_ready low 5 cycles -> host_re held 0, state holds.
  - word_out_ready toggling 1/0 -> each word delivered exactly once, in order.
  - write with host_wr_ready low 7 cycles -> host_we only after it rises; data unchanged.
- Simultaneous rd_req and wr_req in IDLE -> read executes and wr_req is ignored; a wr_req during RD_STREAM is also ignored.
- abort at word 7 of WR_FILL -> no host_we, no tx_done, ready=1 the next cycle; a subsequent full write produces the correct line.
- rst_n low during RD_STREAM word 5 -> outputs cleared asynchronously, ready=1 after release; a fresh read streams from word 0.
